// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Watches NCH single-bit inputs for rising and/or falling edges, holds each
//   detected edge as a pending event, and serialises pending events onto a
//   single valid/ready port using round-robin priority. Overruns (a new edge
//   arriving while the channel still holds an undelivered event) are recorded
//   in sticky per-channel flags and a saturating drop counter.
//
// Ports
//   clk        sole clock, posedge
//   rst_n      asynchronous active-low reset
//   inp        channel inputs, synchronous to clk
//   mode       per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   evt_valid  event presented on evt_ch / evt_kind
//   evt_ready  consumer accepts when evt_valid && evt_ready at posedge
//   evt_ch     channel index of presented event
//   evt_kind   1 = rising edge, 0 = falling edge
//   ovf        sticky per-channel overrun flags
//   drop_cnt   saturating count of dropped edges
//   clr_ovf    single-cycle pulse clearing ovf and drop_cnt
//
// Detection state machine
//   state      | meaning
//   ST_WAIT    | first cycle after reset; dly not yet valid, detection gated
//   ST_RUN     | dly holds last sample; edges qualified normally

module edge_event_arbiter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  // derived from NCH; not meant to be overridden
  parameter int CH_W  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    inp,
  input  logic [2*NCH-1:0]  mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_kind,
  output logic [NCH-1:0]    ovf,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_ovf
);

  localparam int SUM_W = ((CNT_W > CH_W + 1) ? CNT_W : CH_W + 1) + 1;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   primed;

  logic [NCH-1:0]   dly;
  logic [NCH-1:0]   pend, pend_nxt;
  logic [NCH-1:0]   pkind, pkind_nxt;
  logic [NCH-1:0]   en_r, en_f, off;
  logic [NCH-1:0]   rise, fall, hit;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   ovr;
  logic [CH_W-1:0]  rr, rr_nxt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             slot_free;
  logic [CH_W:0]    n_ovr;
  logic [SUM_W-1:0] drop_sum;
  logic [CNT_W-1:0] drop_sat;

  // ---------------------------------------------------------------- priming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    primed    = 1'b0;
    case (state)
      ST_WAIT: state_nxt = ST_RUN;
      ST_RUN:  primed    = 1'b1;
      default: state_nxt = ST_WAIT;
    endcase
  end

  // -------------------------------------------------------- edge detection
  always_comb begin
    en_r = '0;
    en_f = '0;
    for (int i = 0; i < NCH; i++) begin
      en_r[i] = mode[2*i];
      en_f[i] = mode[2*i+1];
    end
  end

  assign off  = ~(en_r | en_f);
  assign rise = inp & ~dly;
  assign fall = ~inp & dly;
  assign hit  = {NCH{primed}} & ((en_r & rise) | (en_f & fall));

  // ---------------------------------------------------- round-robin grant
  assign slot_free = !evt_valid || evt_ready;

  // Search starts at rr and wraps; index arithmetic is done in int so a
  // non-power-of-two NCH wraps correctly.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = int'(rr) + k;
      if (j >= NCH) j = j - NCH;
      if (!gnt_found && pend[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(j);
      end
    end
  end

  assign rr_nxt = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++)
      load[i] = slot_free && gnt_found && (gnt_idx == CH_W'(i));
  end

  // ------------------------------------------------------- pending update
  // A new edge on a channel being moved to the output this cycle simply
  // refills the pending slot; it only counts as an overrun when the held
  // event is staying put.
  always_comb begin
    pend_nxt  = pend;
    pkind_nxt = pkind;
    ovr       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (off[i]) begin
        pend_nxt[i] = 1'b0;
      end else if (hit[i] && (!pend[i] || load[i])) begin
        pend_nxt[i]  = 1'b1;
        pkind_nxt[i] = rise[i];
      end else if (hit[i]) begin
        ovr[i] = 1'b1;
      end else if (load[i]) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  // ------------------------------------------------------ drop accounting
  always_comb begin
    n_ovr = '0;
    for (int i = 0; i < NCH; i++)
      n_ovr = n_ovr + (CH_W+1)'(ovr[i]);
  end

  assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_ovr);
  assign drop_sat = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                       : drop_sum[CNT_W-1:0];

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly       <= '0;
      pend      <= '0;
      pkind     <= '0;
      ovf       <= '0;
      drop_cnt  <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_kind  <= 1'b0;
      rr        <= '0;
    end else begin
      dly   <= inp;
      pend  <= pend_nxt;
      pkind <= pkind_nxt;

      if (clr_ovf) begin
        ovf      <= '0;
        drop_cnt <= '0;
      end else begin
        ovf      <= ovf | ovr;
        drop_cnt <= drop_sat;
      end

      if (slot_free) begin
        if (gnt_found) begin
          evt_valid <= 1'b1;
          evt_ch    <= gnt_idx;
          evt_kind  <= pkind[gnt_idx];
          rr        <= rr_nxt;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: table-driven vectors, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.

module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] inp;
  logic [7:0] mode;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_kind;
  logic [3:0] ovf;
  logic [1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.NCH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_kind  (evt_kind),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_evt(input string name, input bit v, input bit [1:0] c, input bit k);
    chk({name, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({name, "_ch"}, 32'(evt_ch), 32'(c));
      chk({name, "_kind"}, 32'(evt_kind), 32'(k));
    end
  endtask

  // ------------------------------------------------------ reference model
  bit [3:0] m_dly, m_pend, m_pkind, m_ovf;
  int       m_drop, m_ch, m_rr;
  bit       m_valid, m_kind, m_primed;

  task automatic model_reset();
    m_dly = 0; m_pend = 0; m_pkind = 0; m_ovf = 0;
    m_drop = 0; m_ch = 0; m_rr = 0;
    m_valid = 0; m_kind = 0; m_primed = 0;
  endtask

  // Predicts the state after the coming posedge from the current inputs.
  task automatic model_step();
    bit       free, r, f, hit;
    bit [1:0] md;
    bit [3:0] old_kind;
    int       g, drops;
    free = !m_valid || evt_ready;
    g = -1;
    if (free)
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    old_kind = m_pkind;
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      r   = inp[i] && !m_dly[i];
      f   = !inp[i] && m_dly[i];
      md  = mode[2*i +: 2];
      hit = m_primed && ((md[0] && r) || (md[1] && f));
      if (md == 2'b00) m_pend[i] = 0;
      else if (hit && (!m_pend[i] || g == i)) begin
        m_pend[i] = 1; m_pkind[i] = r;
      end else if (hit) begin
        m_ovf[i] = 1; drops++;
      end else if (g == i) m_pend[i] = 0;
    end
    if (g >= 0) begin
      m_valid = 1; m_ch = g; m_kind = old_kind[g]; m_rr = (g + 1) % 4;
    end else if (free) m_valid = 0;
    m_drop = (m_drop + drops > 3) ? 3 : m_drop + drops;
    if (clr_ovf) begin m_ovf = 0; m_drop = 0; end
    m_dly = inp;
    m_primed = 1;
  endtask

  task automatic check_model();
    chk("rnd_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rnd_ch", 32'(evt_ch), 32'(m_ch));
      chk("rnd_kind", 32'(evt_kind), 32'(m_kind));
    end
    chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
    chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Leaves the bench at the negedge where rst_n is released.
  task automatic do_reset(input logic [3:0] i_inp, input logic [7:0] i_mode);
    @(negedge clk);
    rst_n = 0; inp = i_inp; mode = i_mode; evt_ready = 0; clr_ovf = 0;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [3:0] inp;
    logic [7:0] mode;
    logic       rdy;
    logic       v;
    logic [1:0] ch;
    logic       k;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] i, input logic [7:0] m, input logic r,
                              input logic v, input logic [1:0] c, input logic k);
    vec_t t;
    t.inp = i; t.mode = m; t.rdy = r; t.v = v; t.ch = c; t.k = k;
    return t;
  endfunction

  initial begin
    rst_n = 0; inp = 0; mode = 0; evt_ready = 0; clr_ovf = 0;

    // round-robin twice (pointer wraps), then a single rising edge on ch0
    tbl.push_back(mk(4'h0, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'hF, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 0, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 1, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 2, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 3, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'hF, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 0, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 1, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 2, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 1, 3, 1));
    tbl.push_back(mk(4'hF, 8'h55, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 8'h01, 1, 0, 0, 0));
    tbl.push_back(mk(4'h1, 8'h01, 1, 0, 0, 0));
    tbl.push_back(mk(4'h1, 8'h01, 1, 1, 0, 1));
    tbl.push_back(mk(4'h1, 8'h01, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 8'h01, 1, 0, 0, 0));
    tbl.push_back(mk(4'h0, 8'h01, 1, 0, 0, 0));

    // --- post-reset priming: input high at release gives no event
    do_reset(4'b0001, 8'hFF);
    evt_ready = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("prime_valid", 32'(evt_valid), 32'd0);
      chk("prime_ovf", 32'(ovf), 32'd0);
    end

    // --- table vectors
    do_reset(4'h0, 8'h55);
    foreach (tbl[i]) begin
      inp = tbl[i].inp; mode = tbl[i].mode; evt_ready = tbl[i].rdy;
      @(negedge clk);
      chk_evt($sformatf("tbl%0d", i), tbl[i].v, tbl[i].ch, tbl[i].k);
      chk("tbl_ovf", 32'(ovf), 32'd0);
      chk("tbl_drop", 32'(drop_cnt), 32'd0);
    end

    // --- both edges, consumer stalled
    do_reset(4'h0, 8'h30);
    @(negedge clk); inp = 4'b0100;
    @(negedge clk); chk_evt("both_p1", 0, 0, 0);
    @(negedge clk); chk_evt("both_p2", 1, 2, 1);
    @(negedge clk); chk_evt("both_p3", 1, 2, 1);
    @(negedge clk); inp = 4'b0000;
    @(negedge clk); chk_evt("both_hold", 1, 2, 1);
    chk("both_ovf", 32'(ovf), 32'd0);
    @(negedge clk); chk_evt("both_hold2", 1, 2, 1);
    chk("both_ovf2", 32'(ovf), 32'd0);
    evt_ready = 1;
    @(negedge clk); chk_evt("both_second", 1, 2, 0);
    @(negedge clk); chk_evt("both_done", 0, 0, 0);

    // --- overrun and saturation
    do_reset(4'h0, 8'h0C);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); inp = inp ^ 4'b0010;
    end
    @(negedge clk);
    chk("ovr_ovf", 32'(ovf), 32'b0010);
    chk("ovr_drop", 32'(drop_cnt), 32'd3);
    chk_evt("ovr_evt", 1, 1, 1);
    clr_ovf = 1;
    @(negedge clk); clr_ovf = 0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    inp = inp ^ 4'b0010; clr_ovf = 1;
    @(negedge clk); clr_ovf = 0;
    chk("clrpri_ovf", 32'(ovf), 32'd0);
    chk("clrpri_drop", 32'(drop_cnt), 32'd0);
    inp = inp ^ 4'b0010;
    @(negedge clk);
    chk("ovr2_ovf", 32'(ovf), 32'b0010);
    chk("ovr2_drop", 32'(drop_cnt), 32'd1);
    chk_evt("ovr2_evt", 1, 1, 1);

    // --- disabling a channel discards its pending event
    do_reset(4'h0, 8'h41);
    @(negedge clk); inp = 4'b0001;
    @(negedge clk); inp = 4'b1001;
    @(negedge clk); chk_evt("dis_ch0", 1, 0, 1);
    mode = 8'h01;
    @(negedge clk); chk_evt("dis_hold", 1, 0, 1);
    evt_ready = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); chk_evt("dis_none", 0, 0, 0);
    end
    evt_ready = 0;
    inp = 4'b0000;
    @(negedge clk); inp = 4'b0001;
    @(negedge clk);
    @(negedge clk); chk_evt("midrst_pre", 1, 0, 1);
    #2 rst_n = 0;
    #1 chk("midrst_valid", 32'(evt_valid), 32'd0);

    // --- randomized against the reference model
    do_reset(4'h0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      check_model();
      if ($urandom_range(7) == 0) mode = 8'($urandom);
      inp       = 4'($urandom);
      evt_ready = ($urandom_range(3) != 0);
      clr_ovf   = ($urandom_range(31) == 0);
      model_step();
      @(negedge clk);
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller. Watches NCH single-bit inputs and detects a rising, falling or either edge per channel, as configured.
- Each detected edge is held as a pending event. A round-robin arbiter then serialises pending events onto one valid/ready event port for a downstream consumer (interrupt logic, event FIFO).
- Records overruns per channel in sticky flags and a saturating drop counter.

Parameters:
- NCH, 4: number of input channels (2..16).
- CNT_W, 8: width of the saturating drop counter.
- CH_W, $clog2(NCH): channel index width; derived, not overridden.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- inp  in  NCH  channel inputs, synchronous to clk.
- mode  in  2*NCH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- evt_valid  out  1  event available on evt_ch/evt_kind.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at posedge.
- evt_ch  out  CH_W  channel index of the presented event.
- evt_kind  out  1  1 = rising edge, 0 = falling edge.
- ovf  out  NCH  sticky per-channel overrun flags.
- drop_cnt  out  CNT_W  saturating count of dropped edges.
- clr_ovf  in  1  single-cycle pulse; clears ovf and drop_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dly[NCH], pend[NCH], pkind[NCH], ovf, drop_cnt, evt_ch, evt_kind, evt_valid all 0.
  - Round-robin pointer rr = 0. primed = 0.
- Sampling:
  - dly[i] <= inp[i] every posedge, regardless of mode.
  - rise[i] = inp[i] & ~dly[i]; fall[i] = ~inp[i] & dly[i]; both are combinational.
  - All detection is gated off while primed = 0.
  - primed goes to 1 at the first posedge after reset release. An input already high at reset release therefore produces no event.
- Qualification:
  - hit[i] = primed & ((mode bit 2i & rise[i]) | (mode bit 2i+1 & fall[i])).
  - kind = rise[i].
- Pending update at posedge, per channel i:
  - If mode[i] == 00: pend[i] <= 0. Any pending event is discarded without ovf or drop.
  - Else if hit[i] && (!pend[i] || load_i): pend[i] <= 1; pkind[i] <= kind. load_i means channel i is moved to the output this cycle; that case is not an overrun.
  - Else if hit[i] && pend[i]: overrun. The older event is retained and the new edge is dropped. ovf[i] <= 1.
  - Else if load_i: pend[i] <= 0.
- Output slot:
  - slot_free = !evt_valid || evt_ready.
  - When slot_free and any pend bit is set: grant the first set pend[j], searching j = rr, rr+1, ..., NCH-1, 0, ... (wrapping).
  - On grant: evt_valid <= 1, evt_ch <= j, evt_kind <= pkind[j], rr <= j+1 (mod NCH).
  - When slot_free and no pend bit is set: evt_valid <= 0.
  - evt_ch and evt_kind stay stable while evt_valid && !evt_ready.
- Latency:
  - Edge visible on inp before posedge k → pend set at k → evt_valid high after k+1, if the slot is free.
  - Back-to-back acceptance with evt_ready held high gives one event per cycle.
- drop_cnt:
  - Increments by the number of overrun channels in that cycle.
  - Saturates at 2^CNT_W - 1; never wraps.
- clr_ovf:
  - ovf <= 0, drop_cnt <= 0.
  - clr_ovf takes priority over a same-cycle overrun: flags and count end at 0.
- Reset mid-operation: the pending event and the presented event are lost; evt_valid drops immediately (asynchronous).
- Mode change:
  - Takes effect on the next posedge's qualification.
  - An event already in the output slot is unaffected by a later mode change.

Test Plan:
- Post-reset priming: inp = 4'b0001 held through reset release, mode = all 11 → no evt_valid for 10 cycles; ovf = 0.
- Single rising edge: evt_ready = 1, mode[1:0] = 01, pulse inp[0] 0→1 → evt_valid high exactly 2 posedges later for 1 cycle, evt_ch = 0, evt_kind = 1. The following 1→0 produces no event.
- Both edges, consumer stalled: evt_ready = 0, mode ch2 = 11, toggle inp[2] 0→1, then 1→0 four cycles later:
  - evt_ch = 2 with evt_kind = 1 is held.
  - The falling edge stays pending: ovf = 0.
  - Raise evt_ready → second event, kind 0, on the next cycle.
- Round-robin fairness: evt_ready = 1, all channels in mode 01, rise all four in the same cycle → events on ch 0, 1, 2, 3 in consecutive cycles. Repeat → order again starts at rr = 0 (the pointer wrapped).
- Overrun and saturation: CNT_W = 2, evt_ready = 0, ch1 mode 11, toggle inp[1] six times → ovf[1] = 1, drop_cnt = 3 (saturated). The original rising event is still presented. Pulse clr_ovf → ovf = 0, drop_cnt = 0.
- Disable discards: ch3 pending (slot occupied by ch0, evt_ready = 0), set mode ch3 = 00 → after acceptance of ch0, evt_valid falls and no ch3 event appears. Mid-stall rst_n pulse → evt_valid 0 immediately.
